// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word and state types, round constants,
// initial hash value, the compression helper functions and the FSM encoding.
package sha256_pkg;

  typedef logic [31:0] word_t;

  // Element 0 holds a (or H0); element 7 holds h (or H7).
  typedef logic [7:0][31:0] state_t;

  // Element 0 is the oldest schedule word, which is W_t for the current round.
  typedef logic [15:0][31:0] window_t;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_RND1,
    ST_ADD1,
    ST_RND2,
    ST_ADD2,
    ST_RND3,
    ST_FIN,
    ST_DONE
  } fsm_t;

  // The first listed word lands in element 7, so IV[0] is 6a09e667.
  localparam state_t IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic word_t bsig0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t bsig1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ssig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Splits a big-endian 512-bit chunk into the schedule window, first word at element 0.
  function automatic window_t toWindow(input logic [511:0] chunk);
    window_t r;
    for (int i = 0; i < 16; i++) begin
      r[i] = chunk[511 - 32*i -: 32];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: a..h, W_t and K_t in, next a..h out.
module sha256_round
  import sha256_pkg::*;
(
  input  state_t i_state,
  input  word_t  i_w,
  input  word_t  i_k,
  output state_t o_state
);

  word_t w_t1;
  word_t w_t2;

  // Standard round: temporaries T1/T2, then a..h rotate down with d and h absorbing T1.
  always_comb begin
    w_t1 = i_state[7] + bsig1(i_state[4]) + ch(i_state[4], i_state[5], i_state[6]) + i_k + i_w;
    w_t2 = bsig0(i_state[0]) + maj(i_state[0], i_state[1], i_state[2]);
    o_state[0] = w_t1 + w_t2;
    o_state[1] = i_state[0];
    o_state[2] = i_state[1];
    o_state[3] = i_state[2];
    o_state[4] = i_state[3] + w_t1;
    o_state[5] = i_state[4];
    o_state[6] = i_state[5];
    o_state[7] = i_state[6];
  end

endmodule

// File: rtl/doublesha.sv
// Double SHA-256 of a fixed 80-byte message, one round per clock.
// The core starts on reset release and finishes exactly 196 edges later,
// so identical instances always complete on the same cycle.
module doublesha
  import sha256_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [639:0] block_info,
  output logic         complete,
  output logic [255:0] hash
);

  fsm_t          r_state;
  logic [5:0]    r_cnt;
  logic [127:0]  r_tail;
  state_t        r_h;
  state_t        r_work;
  window_t       r_w;
  logic [255:0]  r_hash;
  logic          r_complete;

  state_t        w_next;
  state_t        w_sum;
  word_t         w_wnew;
  logic [255:0]  w_digest;
  logic [255:0]  w_final;

  sha256_round u_round (
    .i_state (r_work),
    .i_w     (r_w[0]),
    .i_k     (K[r_cnt]),
    .o_state (w_next)
  );

  // Schedule word W[t+16], chunk feed-forward sums and big-endian packing of both digests.
  always_comb begin
    w_wnew   = ssig1(r_w[14]) + r_w[9] + ssig0(r_w[1]) + r_w[0];
    w_sum    = '0;
    w_digest = '0;
    w_final  = '0;
    for (int i = 0; i < 8; i++) begin
      w_sum[i]                    = r_h[i] + r_work[i];
      w_digest[255 - 32*i -: 32]  = r_h[i] + r_work[i];
      w_final[255 - 32*i -: 32]   = IV[i] + r_work[i];
    end
  end

  // Sequencer: load, three 64-round passes with feed-forward steps between them, then hold.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= ST_LOAD;
      r_cnt      <= '0;
      r_tail     <= '0;
      r_h        <= '0;
      r_work     <= '0;
      r_w        <= '0;
      r_hash     <= '0;
      r_complete <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          // Chunk 0 goes straight into the window; only the tail is needed later.
          r_tail  <= block_info[127:0];
          r_h     <= IV;
          r_work  <= IV;
          r_w     <= toWindow(block_info[639:128]);
          r_cnt   <= '0;
          r_state <= ST_RND1;
        end
        ST_RND1, ST_RND2, ST_RND3: begin
          r_work <= w_next;
          r_w    <= {w_wnew, r_w[15:1]};
          r_cnt  <= r_cnt + 6'd1;
          if (r_cnt == 6'd63) begin
            r_state <= (r_state == ST_RND1) ? ST_ADD1 :
                       (r_state == ST_RND2) ? ST_ADD2 : ST_FIN;
          end
        end
        ST_ADD1: begin
          r_h     <= w_sum;
          r_work  <= w_sum;
          r_w     <= toWindow({r_tail, 32'h80000000, 288'b0, 64'd640});
          r_state <= ST_RND2;
        end
        ST_ADD2: begin
          r_h     <= IV;
          r_work  <= IV;
          r_w     <= toWindow({w_digest, 32'h80000000, 160'b0, 64'd256});
          r_state <= ST_RND3;
        end
        ST_FIN: begin
          r_hash     <= w_final;
          r_complete <= 1'b1;
          r_state    <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
      endcase
    end
  end

  assign complete = r_complete;
  assign hash     = r_hash;

endmodule

// File: tb/tb_doublesha.sv
// Self-checking bench for doublesha: independent software double-SHA-256 model
// feeding an expected-digest queue, plus a bank of ten parallel instances.
module tb_doublesha;

  localparam logic [639:0] GEN_MSG = 640'h0100000000000000000000000000000000000000000000000000000000000000000000003ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a29ab5f49ffff001d1dac2b7c;
  localparam logic [255:0] GEN_HASH = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
  localparam logic [255:0] TB_IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [31:0] TB_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk;
  logic         rst_n;
  logic [639:0] blk;
  logic         complete;
  logic [255:0] hash;

  logic         prst;
  logic [639:0] pblk [10];
  logic [9:0]   pcomplete;
  logic [255:0] phash [10];

  int checks;
  int errors;
  int edges;
  logic [255:0] expQ [$];
  logic [639:0] genMsg;
  logic [639:0] msg;

  doublesha dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .block_info (blk),
    .complete   (complete),
    .hash       (hash)
  );

  for (genvar g = 0; g < 10; g++) begin : g_par
    doublesha u_par (
      .clk_i      (clk),
      .rst_i      (prst),
      .block_info (pblk[g]),
      .complete   (pcomplete[g]),
      .hash       (phash[g])
    );
  end

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression with a full 64-entry message schedule.
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blkIn);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = blkIn[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    for (int j = 0; j < 8; j++) v[j] = hin[255 - 32*j -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TB_K[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    r = '0;
    for (int j = 0; j < 8; j++) r[255 - 32*j -: 32] = hin[255 - 32*j -: 32] + v[j];
    return r;
  endfunction

  function automatic logic [255:0] dsha(input logic [639:0] m);
    logic [1023:0] p1;
    logic [511:0]  p2;
    logic [255:0]  h;
    p1 = {m, 8'h80, 312'b0, 64'd640};
    h  = compress(TB_IV, p1[1023:512]);
    h  = compress(h, p1[511:0]);
    p2 = {h, 8'h80, 184'b0, 64'd256};
    return compress(TB_IV, p2);
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reset (checking the cleared outputs), queue the model digest, release and time the run.
  task automatic applyStimulus(input logic [639:0] m, input bit clobber);
    @(negedge clk);
    rst_n = 1'b0;
    blk   = m;
    #1;
    checkOutput("rst_complete", 256'(complete), 256'd0);
    checkOutput("rst_hash", hash, 256'd0);
    expQ.push_back(dsha(m));
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    while (!complete && edges < 300) begin
      @(posedge clk);
      #1;
      edges++;
      if (clobber && edges == 1) blk = '0;
    end
    checkOutput("latency", 256'(edges), 256'd196);
    checkOutput("hash", hash, expQ.pop_front());
  endtask

  initial begin
    checks = 0;
    errors = 0;
    genMsg = GEN_MSG;
    rst_n  = 1'b0;
    blk    = '0;
    prst   = 1'b0;
    for (int i = 0; i < 10; i++) pblk[i] = '0;

    $display("[TB] genesis vector");
    applyStimulus(genMsg, 1'b0);
    checkOutput("genesis_const", hash, GEN_HASH);

    $display("[TB] genesis with block_info cleared after load, then hold");
    applyStimulus(genMsg, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (i % 10 == 9) begin
        checkOutput("hold_complete", 256'(complete), 256'd1);
        checkOutput("hold_hash", hash, GEN_HASH);
      end
    end

    $display("[TB] abort at edge 100");
    @(negedge clk);
    rst_n = 1'b0;
    blk   = genMsg;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_complete", 256'(complete), 256'd0);
    checkOutput("abort_hash", hash, 256'd0);
    applyStimulus(genMsg, 1'b0);
    checkOutput("rerun_genesis", hash, GEN_HASH);

    $display("[TB] incremented nonce");
    msg = genMsg;
    msg[31:0] = 32'h1dac2b7d;
    applyStimulus(msg, 1'b0);
    checkOutput("nonce_differs", 256'(hash != GEN_HASH), 256'd1);

    $display("[TB] random vectors");
    for (int j = 0; j < 20; j++) begin
      for (int k = 0; k < 20; k++) msg[32*k +: 32] = $urandom;
      applyStimulus(msg, 1'b0);
    end

    $display("[TB] ten parallel instances");
    @(negedge clk);
    prst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pblk[i] = {genMsg[639:32], 32'(i)};
      expQ.push_back(dsha(pblk[i]));
    end
    @(negedge clk);
    prst = 1'b1;
    edges = 0;
    while (pcomplete == 10'd0 && edges < 300) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput("par_latency", 256'(edges), 256'd196);
    checkOutput("par_sync", 256'(pcomplete), 256'h3ff);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("par_hash%0d", i), phash[i], expQ.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
